// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // One spare bit so MAX_BURST itself is representable without wrap.
    function automatic int beat_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_req scanning upward from i_last+1, wrapping.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_found
);

    int            w_pos;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        w_pos    = 0;
        w_cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos  = (int'(i_last) + k) % NREQ;
            w_cand = IW'(w_pos);
            if (!o_found && i_req[w_cand]) begin
                o_found  = 1'b1;
                o_idx    = w_cand;
                o_onehot = NREQ'(1) << w_cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Optional per-requester beat counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int CW        = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NREQ-1:0]    i_req_valid,
    input  logic [NREQ*DW-1:0] i_req_data,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic               i_fifo_full,
    output logic               o_fifo_wr_en,
    output logic [DW-1:0]      o_fifo_wr_data,
    output logic [NREQ-1:0]    o_grant,
    output logic               o_busy,
    input  logic               i_stats_clr,
    output logic [NREQ*CW-1:0] o_grant_cnt
);

    // state | meaning
    // IDLE  | no owner; pick next requester round-robin from r_last+1
    // GRANT | r_grant owns the write port until burst end or owner drops valid

    localparam int IW = idx_width(NREQ);
    localparam int BW = beat_width(MAX_BURST);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("fifo_wr_arbiter: NREQ must be 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
        $error("fifo_wr_arbiter: MAX_BURST must be 1..16");
    end

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] w_grant_nxt;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   w_last_nxt;
    logic [BW-1:0]   r_beat_cnt;
    logic [BW-1:0]   w_beat_nxt;

    logic [NREQ-1:0] w_ready;
    logic            w_transfer;
    logic            w_owner_valid;
    logic [DW-1:0]   w_wr_data;
    logic [NREQ-1:0] w_pick_onehot;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_found;

    fifo_wr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req    (i_req_valid),
        .i_last   (r_last),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_found  (w_pick_found)
    );

    // r_grant is zero in reset, so ready/wr_en are inherently low there.
    assign w_ready       = r_grant & {NREQ{~i_fifo_full}};
    assign w_transfer    = |(i_req_valid & w_ready);
    assign w_owner_valid = |(i_req_valid & r_grant);

    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_wr_data = w_wr_data | i_req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_pick_onehot;
                    w_last_nxt  = w_pick_idx;
                    w_beat_nxt  = '0;
                end
            end
            ST_GRANT: begin
                // Losing valid releases even under fifo_full, so a stalled FIFO cannot pin an absent owner.
                if (!w_owner_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_beat_nxt  = '0;
                end else if (w_transfer) begin
                    if (r_beat_cnt == BEAT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat_cnt + BW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_last     <= IW'(NREQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    assign o_req_ready    = w_ready;
    assign o_fifo_wr_en   = w_transfer;
    assign o_fifo_wr_data = w_wr_data;
    assign o_grant        = r_grant;
    assign o_busy         = (r_state == ST_GRANT);

`ifdef FIFO_WR_ARB_STATS_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_stats
        logic [CW-1:0] r_cnt;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt <= '0;
            end else if (i_stats_clr) begin
                r_cnt <= '0;
            end else if (i_req_valid[g] && w_ready[g] && (r_cnt != {CW{1'b1}})) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
        assign o_grant_cnt[g*CW +: CW] = r_cnt;
    end
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = i_stats_clr;
    assign o_grant_cnt        = '0;
`endif

endmodule
